// File: rtl/servo_360_sequenciador_pkg.sv
// Shared constants for the quarter-turn servo sequencer: state codes
// (also shown on db_estado) and default timing for a 50 MHz clock.
package servo_seq_pkg;

  localparam logic [2:0] EST_OCIOSO  = 3'b000;
  localparam logic [2:0] EST_ENVIA   = 3'b001;
  localparam logic [2:0] EST_AGUARDA = 3'b010;
  localparam logic [2:0] EST_PAUSA   = 3'b011;
  localparam logic [2:0] EST_FIM     = 3'b100;
  localparam logic [2:0] EST_ERRO    = 3'b111;

  localparam int unsigned CLOCK_HZ              = 50_000_000;
  localparam int unsigned PAUSA_CICLOS_PADRAO   = CLOCK_HZ / 2;  // 0.5 s
  localparam int unsigned TIMEOUT_CICLOS_PADRAO = CLOCK_HZ * 3;  // 3 s

endpackage

// File: rtl/servo_360_sequenciador_if.sv
// Command/status bundle between the solver FSM, the sequencer and the
// servo block.  The sequencer uses the slave modport.
interface servo_360_sequenciador_if;
  logic       iniciar;
  logic [1:0] quantidade;
  logic       pronto;
  logic       ocupado;
  logic       erro;
  logic [1:0] voltas_feitas;
  logic       servo_iniciar;
  logic       servo_pronto;
  logic [2:0] db_estado;

  modport master (
    output iniciar, quantidade, servo_pronto,
    input  pronto, ocupado, erro, voltas_feitas, servo_iniciar, db_estado
  );

  modport slave (
    input  iniciar, quantidade, servo_pronto,
    output pronto, ocupado, erro, voltas_feitas, servo_iniciar, db_estado
  );
endinterface

// File: rtl/servo_360_sequenciador_timer.sv
// Cycle up-counter: zera clears, conta advances, fim flags the last
// count (M-1) so the owner can leave its state on that edge.
module servo_seq_timer #(
  parameter int unsigned M = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned    W      = $clog2(M) + 1;
  localparam logic [W-1:0]   ULTIMO = W'(M - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + W'(1);
    end
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/servo_360_sequenciador.sv
// Runs one face move of 1-3 quarter turns on a continuous-rotation servo,
// with a settle pause between turns and a per-turn timeout.
//
// estado  | meaning
// OCIOSO  | idle, waiting for iniciar
// ENVIA   | one-cycle start pulse to the servo
// AGUARDA | waiting for servo_pronto, timeout running
// PAUSA   | settle time before the next quarter turn
// FIM     | one-cycle pronto pulse
// ERRO    | servo timed out, raise erro
module servo_360_sequenciador
  import servo_seq_pkg::*;
#(
  parameter int unsigned PAUSA_CICLOS   = PAUSA_CICLOS_PADRAO,
  parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic                      clock,
  input  logic                      reset,
  servo_360_sequenciador_if.slave   bus
);

  logic [2:0] estado;
  logic [2:0] prox_estado;
  logic [1:0] restante;
  logic [1:0] voltas;
  logic       erro_r;
  logic       pausa_fim;
  logic       timeout_fim;

  servo_seq_timer #(.M(PAUSA_CICLOS)) u_pausa (
    .clock (clock),
    .reset (reset),
    .zera  (estado != EST_PAUSA),
    .conta (estado == EST_PAUSA),
    .fim   (pausa_fim)
  );

  servo_seq_timer #(.M(TIMEOUT_CICLOS)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (estado == EST_ENVIA),
    .conta (estado == EST_AGUARDA),
    .fim   (timeout_fim)
  );

  always_comb begin
    prox_estado = estado;
    case (estado)
      EST_OCIOSO: begin
        if (bus.iniciar) begin
          prox_estado = (bus.quantidade == 2'd0) ? EST_FIM : EST_ENVIA;
        end
      end
      EST_ENVIA:   prox_estado = EST_AGUARDA;
      EST_AGUARDA: begin
        // a reply on the final timeout cycle still counts as success
        if (bus.servo_pronto) begin
          prox_estado = (restante == 2'd1) ? EST_FIM : EST_PAUSA;
        end else if (timeout_fim) begin
          prox_estado = EST_ERRO;
        end
      end
      EST_PAUSA: begin
        if (pausa_fim) begin
          prox_estado = EST_ENVIA;
        end
      end
      EST_FIM:  prox_estado = EST_OCIOSO;
      EST_ERRO: prox_estado = EST_OCIOSO;
      default:  prox_estado = EST_OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= EST_OCIOSO;
      restante <= 2'd0;
      voltas   <= 2'd0;
      erro_r   <= 1'b0;
    end else begin
      estado <= prox_estado;
      if (estado == EST_OCIOSO && bus.iniciar) begin
        restante <= bus.quantidade;
        voltas   <= 2'd0;
        erro_r   <= 1'b0;
      end
      if (estado == EST_AGUARDA) begin
        if (bus.servo_pronto) begin
          restante <= restante - 2'd1;
          voltas   <= voltas + 2'd1;
        end else if (timeout_fim) begin
          erro_r <= 1'b1;
        end
      end
    end
  end

  assign bus.servo_iniciar = (estado == EST_ENVIA);
  assign bus.pronto        = (estado == EST_FIM);
  assign bus.ocupado       = (estado != EST_OCIOSO);
  assign bus.erro          = erro_r;
  assign bus.voltas_feitas = voltas;
  assign bus.db_estado     = estado;

endmodule

// File: tb/tb_servo_360_sequenciador.sv
// Bench for the servo sequencer: random moves against a timing model of
// turn starts, completion and timeout, plus reset scenarios.
module tb_servo_360_sequenciador;

  localparam int PAUSA   = 4;
  localparam int TIMEOUT = 20;
  localparam int MUDO    = 99;

  logic clock;
  logic reset;
  int   ciclo;
  int   checks;
  int   failures;
  int   agendado;

  int ini_q[$];
  int pronto_q[$];
  int erro_q[$];
  int atraso_q[$];

  servo_360_sequenciador_if bus ();

  servo_360_sequenciador #(
    .PAUSA_CICLOS   (PAUSA),
    .TIMEOUT_CICLOS (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    ciclo = 0;
    forever begin
      @(posedge clock);
      ciclo = ciclo + 1;
    end
  end

  // Observations are stamped with the edge at which the DUT output is sampled.
  initial begin
    agendado         = -1;
    bus.servo_pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.servo_iniciar === 1'b1) begin
        ini_q.push_back(ciclo + 1);
        if (atraso_q.size() > 0) begin
          int k;
          k = atraso_q.pop_front();
          if (k <= TIMEOUT) agendado = ciclo + 1 + k;
        end
      end
      if (bus.pronto === 1'b1) pronto_q.push_back(ciclo + 1);
      if (bus.db_estado === 3'b111) erro_q.push_back(ciclo + 1);
      bus.servo_pronto = (ciclo + 1 == agendado);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: obtido=tempo_esgotado esperado=fim_da_simulacao");
    $fatal(1, "watchdog");
  end

  task automatic verifica(input string tag, input int obs, input int esp);
    checks++;
    if (obs !== esp) begin
      failures++;
      $display("FAIL %s: obtido=%0d esperado=%0d", tag, obs, esp);
    end
  endtask

  task automatic verifica_zerado(input string tag);
    verifica({tag, "_pronto"},        int'(bus.pronto),        0);
    verifica({tag, "_ocupado"},       int'(bus.ocupado),       0);
    verifica({tag, "_erro"},          int'(bus.erro),          0);
    verifica({tag, "_servo_iniciar"}, int'(bus.servo_iniciar), 0);
    verifica({tag, "_voltas"},        int'(bus.voltas_feitas), 0);
    verifica({tag, "_db_estado"},     int'(bus.db_estado),     0);
  endtask

  // One move: k values are servo reply delays per turn, MUDO = never replies.
  task automatic executa(input int q, input int k0, input int k1, input int k2,
                         input bit extra);
    int ks[3];
    int esp_ini[$];
    int t, s, e, i;
    int esp_pronto, esp_voltas, esp_erro_t;
    bit esp_erro;
    ks = '{k0, k1, k2};
    ini_q.delete();
    pronto_q.delete();
    erro_q.delete();
    atraso_q.delete();
    for (int j = 0; j < q; j++) atraso_q.push_back(ks[j]);

    @(negedge clock);
    bus.iniciar    = 1'b1;
    bus.quantidade = 2'(q);
    t = ciclo + 1;
    @(negedge clock);
    bus.iniciar    = 1'b0;
    bus.quantidade = 2'($urandom_range(0, 3));
    verifica("ocupado_ativo", int'(bus.ocupado), 1);

    if (extra && q > 0) begin
      @(negedge clock);
      bus.iniciar    = 1'b1;
      bus.quantidade = 2'd3;
      @(negedge clock);
      bus.iniciar = 1'b0;
    end

    esp_pronto = -1;
    esp_erro   = 1'b0;
    esp_erro_t = -1;
    esp_voltas = 0;
    s = t + 1;
    e = t;
    if (q == 0) begin
      esp_pronto = t + 1;
    end
    i = 0;
    while (i < q && !esp_erro) begin
      esp_ini.push_back(s);
      if (ks[i] > TIMEOUT) begin
        esp_erro   = 1'b1;
        esp_erro_t = s + TIMEOUT + 1;
        e          = s + TIMEOUT;
      end else begin
        esp_voltas++;
        if (i == q - 1) begin
          esp_pronto = s + ks[i] + 1;
          e          = s + ks[i];
        end else begin
          s = s + ks[i] + PAUSA + 1;
        end
      end
      i++;
    end

    while (ciclo < e + 3) @(negedge clock);

    verifica("n_servo_iniciar", ini_q.size(), esp_ini.size());
    for (int j = 0; j < esp_ini.size() && j < ini_q.size(); j++)
      verifica("t_servo_iniciar", ini_q[j] - t, esp_ini[j] - t);
    verifica("n_pronto", pronto_q.size(), (esp_pronto < 0) ? 0 : 1);
    if (esp_pronto >= 0 && pronto_q.size() == 1)
      verifica("t_pronto", pronto_q[0] - t, esp_pronto - t);
    verifica("n_estado_erro", erro_q.size(), int'(esp_erro));
    if (esp_erro && erro_q.size() == 1)
      verifica("t_estado_erro", erro_q[0] - t, esp_erro_t - t);
    verifica("voltas_feitas", int'(bus.voltas_feitas), esp_voltas);
    verifica("erro", int'(bus.erro), int'(esp_erro));
    verifica("ocupado_final", int'(bus.ocupado), 0);
    verifica("db_estado_final", int'(bus.db_estado), 0);
  endtask

  task automatic k_aleatorio(output int k);
    k = ($urandom_range(0, 6) == 0) ? MUDO : $urandom_range(1, TIMEOUT);
  endtask

  initial begin
    int t, q, k0, k1, k2;
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    bus.iniciar    = 1'b0;
    bus.quantidade = 2'd1;

    repeat (2) @(negedge clock);
    bus.iniciar = 1'b1;
    repeat (3) @(negedge clock);
    verifica_zerado("reset");
    bus.iniciar = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    verifica_zerado("pos_reset");

    executa(1, 6, 0, 0, 1'b0);
    executa(3, 6, 6, 6, 1'b0);
    executa(0, 0, 0, 0, 1'b0);
    executa(2, 8, 5, 0, 1'b1);
    executa(1, MUDO, 0, 0, 1'b0);
    executa(2, 3, 5, 0, 1'b0);
    executa(1, TIMEOUT, 0, 0, 1'b0);
    executa(3, 4, MUDO, 0, 1'b0);
    executa(3, 1, TIMEOUT, 1, 1'b1);

    for (int n = 0; n < 14; n++) begin
      q = $urandom_range(0, 3);
      k_aleatorio(k0);
      k_aleatorio(k1);
      k_aleatorio(k2);
      executa(q, k0, k1, k2, 1'(($urandom_range(0, 1))));
    end

    // reset while settling between the two turns of a move
    ini_q.delete();
    atraso_q.delete();
    atraso_q.push_back(6);
    atraso_q.push_back(6);
    @(negedge clock);
    bus.iniciar    = 1'b1;
    bus.quantidade = 2'd2;
    t = ciclo + 1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    while (ciclo < t + 8) @(negedge clock);
    verifica("meio_db_estado", int'(bus.db_estado), 3);
    verifica("meio_voltas", int'(bus.voltas_feitas), 1);
    #2;
    reset = 1'b0;
    #1;
    verifica_zerado("reset_meio");
    @(negedge clock);
    reset = 1'b1;
    ini_q.delete();
    atraso_q.delete();
    repeat (30) @(negedge clock);
    verifica("sem_reinicio", ini_q.size(), 0);
    verifica("ocupado_pos_reset", int'(bus.ocupado), 0);

    executa(2, 2, 7, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_360_sequenciador.md
Name: servo_360_sequenciador

Overview:
- Sequences a single continuous-rotation servo block (iniciar/pronto pulse interface) to execute one face move of 1–3 quarter turns.
- Accepts a command from the top-level solver FSM and pulses the servo once per quarter turn.
- Inserts a settle pause between turns and watches each turn with a timeout.
- Reports completion with a one-cycle pronto and failure with a sticky erro flag.

Parameters:
- PAUSA_CICLOS, 25_000_000: idle cycles between consecutive quarter turns (0.5 s at 50 MHz); legal range ≥1.
- TIMEOUT_CICLOS, 150_000_000: maximum cycles to wait for servo_pronto per turn; legal range ≥2.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous reset, active-low (0 = reset)
- iniciar  in  1  command strobe; sampled only in OCIOSO
- quantidade  in  2  quarter turns requested, 0..3; latched when iniciar is accepted
- pronto  out  1  one-cycle pulse when the move completes
- ocupado  out  1  high in every state except OCIOSO
- erro  out  1  sticky timeout flag
- voltas_feitas  out  2  quarter turns completed in the current/last move
- servo_iniciar  out  1  one-cycle start pulse to the servo block
- servo_pronto  in  1  one-cycle completion pulse from the servo block
- db_estado  out  3  current state encoding, for debug display

Behaviour:
- Reset (reset=0, asynchronous): state = OCIOSO; pronto, ocupado, erro, servo_iniciar = 0; voltas_feitas = 0; all counters = 0.
- Reset mid-move drops servo_iniciar immediately. The servo's own reset is handled elsewhere.
- State encoding (db_estado): OCIOSO=000, ENVIA=001, AGUARDA=010, PAUSA=011, FIM=100, ERRO=111.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- OCIOSO, iniciar=1 at edge t:
  - latch restante=quantidade; clear voltas_feitas and erro.
  - quantidade≠0: go to ENVIA.
  - quantidade=0: go to FIM (pronto at t+1, no servo activity).
- iniciar while not in OCIOSO is ignored; no queuing.
- ENVIA (exactly 1 cycle): servo_iniciar=1; clear the timeout counter; go to AGUARDA.
  - servo_pronto seen in this cycle is ignored as stale.
- AGUARDA: timeout counter increments each cycle.
  - servo_pronto=1: voltas_feitas+1, restante−1. If the new restante=0 go to FIM, else go to PAUSA.
  - Counter reaches TIMEOUT_CICLOS−1 without servo_pronto: go to ERRO.
  - servo_pronto and timeout in the same cycle: servo_pronto wins.
- PAUSA: counts exactly PAUSA_CICLOS cycles, then goes to ENVIA. servo_pronto is ignored here.
- FIM (1 cycle): pronto=1; go to OCIOSO.
- ERRO (1 cycle): set erro=1 (held until the next accepted iniciar or reset); go to OCIOSO; no pronto pulse.
- Latency, quantidade=1, servo answers k cycles after its start pulse:
  - iniciar at t; servo_iniciar at t+1; servo_pronto at t+1+k; pronto at t+2+k.
- Each additional turn adds PAUSA_CICLOS+1+k cycles.
- Counter widths: $clog2 of the parameter, +1 bit. restante and voltas_feitas are 2 bits and never wrap (max 3).
- ocupado is high in ENVIA/AGUARDA/PAUSA/FIM/ERRO and low in OCIOSO.

Decomposition:
- Package servo_seq_pkg holds the state encoding constants and the default timing constants (50 MHz derived values).
- Sub-module servo_seq_timer: a parameterised up-counter with zera/conta inputs and fim output, where fim=1 when the count equals M−1.
- Instantiate servo_seq_timer twice: once for PAUSA and once for the timeout.

Test Plan (PAUSA_CICLOS=4, TIMEOUT_CICLOS=20, servo model answers 6 cycles after servo_iniciar):
- Reset check: hold reset=0, pulse iniciar → all outputs 0, db_estado=000. Release reset → still OCIOSO.
- Single turn: quantidade=1, iniciar at t → servo_iniciar at t+1, servo_pronto at t+7, pronto at t+8, voltas_feitas=1, ocupado low at t+9.
- Three turns: quantidade=3 → exactly 3 servo_iniciar pulses, each 11 cycles apart (4 pause + 1 + 6); one pronto pulse; voltas_feitas=3.
- Zero turns and ignored commands:
  - quantidade=0 → pronto at t+1, no servo_iniciar.
  - iniciar asserted during AGUARDA → ignored; no extra turn.
- Timeout:
  - servo model silent → ERRO after 20 AGUARDA cycles; erro=1, no pronto, voltas_feitas=0, back to OCIOSO.
  - Next iniciar clears erro.
  - servo_pronto on the last timeout cycle → treated as success.
- Reset mid-move: assert reset=0 during PAUSA of a 2-turn move → outputs 0 asynchronously. After release, no further servo_iniciar without a new iniciar.
